// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decrypt round datapath.
// Combinational only; no latency, no backpressure.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  column_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcol_column.sv
// One InvMixColumns column: row 0 in the top byte, x9/x11/x13/x14 constant multipliers.
// Purely combinational; no latency, no backpressure.
module inv_mixcol_column
    import aes_pkg::*;
(
    input  column_t i_col,
    output column_t o_col
);

    logic [7:0] w_a   [4];
    logic [7:0] w_m9  [4];
    logic [7:0] w_m11 [4];
    logic [7:0] w_m13 [4];
    logic [7:0] w_m14 [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_mul
            logic [7:0] w_x2;
            logic [7:0] w_x4;
            logic [7:0] w_x8;

            assign w_a[k]   = i_col[31-8*k -: 8];
            assign w_x2     = xtime(w_a[k]);
            assign w_x4     = xtime(w_x2);
            assign w_x8     = xtime(w_x4);
            assign w_m9[k]  = w_x8 ^ w_a[k];
            assign w_m11[k] = w_x8 ^ w_x2 ^ w_a[k];
            assign w_m13[k] = w_x8 ^ w_x4 ^ w_a[k];
            assign w_m14[k] = w_x8 ^ w_x4 ^ w_x2;
        end
    endgenerate

    assign o_col = {w_m14[0] ^ w_m11[1] ^ w_m13[2] ^ w_m9[3],
                    w_m9[0]  ^ w_m14[1] ^ w_m11[2] ^ w_m13[3],
                    w_m13[0] ^ w_m9[1]  ^ w_m14[2] ^ w_m11[3],
                    w_m11[0] ^ w_m13[1] ^ w_m9[2]  ^ w_m14[3]};

endmodule

// File: rtl/inv_mixcol_sched.sv
// InvMixColumns sequencer: time-shares COLS_PER_CYCLE column units over the 4 state columns.
// Latency 4/COLS_PER_CYCLE+1 cycles (1 when bypassed); one state in flight, result held until out_ready.
module inv_mixcol_sched
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit BYPASS_EN      = 1'b1
)
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_state,
    input  logic   in_bypass,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("inv_mixcol_sched: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    sched_state_e r_fsm;
    logic [1:0]   r_col_cnt;
    state_t       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    column_t    w_cols [4];
    column_t    w_mix  [4];
    logic [1:0] w_pos  [4];
    logic       w_wen  [4];
    logic [2:0] w_cnt_sum;

    // w_pos[c] is column c's slot within the current group; slots >= COLS_PER_CYCLE are not written.
    generate
        for (genvar c = 0; c < 4; c++) begin : g_cols
            assign w_cols[c] = r_state[127-32*c -: 32];
            assign w_pos[c]  = 2'(c) - r_col_cnt;
            assign w_wen[c]  = ({1'b0, w_pos[c]} < 3'(COLS_PER_CYCLE));
        end
        for (genvar g = 0; g < 4; g++) begin : g_units
            if (g < COLS_PER_CYCLE) begin : g_unit
                logic [1:0] w_idx;
                assign w_idx = r_col_cnt + 2'(g);
                inv_mixcol_column u_col (
                    .i_col (w_cols[w_idx]),
                    .o_col (w_mix[g])
                );
            end else begin : g_tie
                assign w_mix[g] = '0;
            end
        end
    endgenerate

    assign w_cnt_sum = {1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_col_cnt   <= 2'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_state;
                        r_col_cnt  <= 2'd0;
                        r_in_ready <= 1'b0;
                        if (in_bypass && BYPASS_EN) begin
                            r_fsm       <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_fsm  <= RUN;
                            r_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    for (int c = 0; c < 4; c++) begin
                        if (w_wen[c]) begin
                            r_state[127-32*c -: 32] <= w_mix[w_pos[c]];
                        end
                    end
                    r_col_cnt <= w_cnt_sum[1:0];
                    // Carry out of the 2-bit counter marks the last column group.
                    if (w_cnt_sum[2]) begin
                        r_fsm       <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_inv_mixcol_sched.sv
// Bench for inv_mixcol_sched: three configurations driven in lockstep plus a standalone column unit,
// checked against a shift-and-add GF(2^8) matrix model.
module tb_inv_mixcol_sched;
    import aes_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    in_valid;
    logic    in_bypass;
    logic    out_ready;
    state_t  in_state;
    logic    w_in_ready  [3];
    logic    w_out_valid [3];
    logic    w_busy      [3];
    state_t  w_out_state [3];
    column_t col_in;
    column_t col_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inv_mixcol_sched u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[0]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(w_out_valid[0]),
        .out_ready(out_ready), .out_state(w_out_state[0]), .busy(w_busy[0]));

    inv_mixcol_sched #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[1]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(w_out_valid[1]),
        .out_ready(out_ready), .out_state(w_out_state[1]), .busy(w_busy[1]));

    inv_mixcol_sched #(.BYPASS_EN(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[2]),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(w_out_valid[2]),
        .out_ready(out_ready), .out_state(w_out_state[2]), .busy(w_busy[2]));

    inv_mixcol_column u_col (
        .i_col (col_in),
        .o_col (col_out)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Russian-peasant multiply, reducing by the full 9-bit AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [8:0] aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = {aa[7:0], 1'b0};
            if (aa[8]) aa = aa ^ 9'h11B;
        end
        return p;
    endfunction

    function automatic state_t ref_inv_mix(input state_t s);
        logic [7:0] base [4] = '{8'd14, 8'd11, 8'd13, 8'd9};
        state_t     r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(s[127-8*(4*c+k) -: 8], base[(k - row + 4) % 4]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic do_txn(input string tag, input state_t s, input logic byp);
        int     lat     [3] = '{0, 0, 0};
        int     exp_lat [3];
        state_t got     [3];
        state_t exp_st  [3];
        state_t m;
        m          = ref_inv_mix(s);
        exp_lat[0] = byp ? 1 : 5;
        exp_lat[1] = byp ? 1 : 2;
        exp_lat[2] = 5;
        exp_st[0]  = byp ? s : m;
        exp_st[1]  = byp ? s : m;
        exp_st[2]  = m;
        for (int d = 0; d < 3; d++) got[d] = '0;

        @(negedge clk);
        check_eq({tag, "_idle_rdy"}, 128'(w_in_ready[0]), 128'(1));
        in_state  = s;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (cyc == 1) check_eq({tag, "_busy"}, 128'(w_busy[0]), 128'(!byp));
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && w_out_valid[d]) begin
                    lat[d] = cyc;
                    got[d] = w_out_state[d];
                end
            end
        end
        check_eq({tag, "_lat_c1"},   128'(lat[0]), 128'(exp_lat[0]));
        check_eq({tag, "_state_c1"}, got[0], exp_st[0]);
        check_eq({tag, "_lat_c4"},   128'(lat[1]), 128'(exp_lat[1]));
        check_eq({tag, "_state_c4"}, got[1], exp_st[1]);
        check_eq({tag, "_lat_nb"},   128'(lat[2]), 128'(exp_lat[2]));
        check_eq({tag, "_state_nb"}, got[2], exp_st[2]);
    endtask

    initial begin
        column_t kv_in  [4] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h4D7EBDF8, 32'hC6C6C6C6};
        column_t kv_out [4] = '{32'hDB135345, 32'hF20A225C, 32'h2D26314C, 32'hC6C6C6C6};
        state_t  s;
        state_t  held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        col_in    = '0;
        #1;
        check_eq("rst_in_ready",  128'(w_in_ready[0]),  128'(1));
        check_eq("rst_out_valid", 128'(w_out_valid[0]), 128'(0));
        check_eq("rst_busy",      128'(w_busy[0]),      128'(0));
        check_eq("rst_out_state", w_out_state[0],       128'(0));

        // Column {a,0,0,0} yields {14a, 9a, 13a, 11a}: every multiplier over all inputs.
        for (int v = 0; v < 256; v++) begin
            col_in = {8'(v), 24'h0};
            #1;
            check_eq("mul14", 128'(col_out[31:24]), 128'(gf_mul(8'(v), 8'd14)));
            check_eq("mul9",  128'(col_out[23:16]), 128'(gf_mul(8'(v), 8'd9)));
            check_eq("mul13", 128'(col_out[15:8]),  128'(gf_mul(8'(v), 8'd13)));
            check_eq("mul11", 128'(col_out[7:0]),   128'(gf_mul(8'(v), 8'd11)));
        end
        col_in = 32'h00010000; #1; check_eq("x11_01", 128'(col_out[31:24]), 128'(8'h0B));
        col_in = 32'h001A0000; #1; check_eq("x11_1A", 128'(col_out[31:24]), 128'(8'hFE));
        col_in = 32'h00FF0000; #1; check_eq("x11_FF", 128'(col_out[31:24]), 128'(8'hA3));

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            s = {kv_in[i], kv_in[i], kv_in[i], kv_in[i]};
            do_txn("kv", s, 1'b0);
            check_eq("kv_const", w_out_state[0], {kv_out[i], kv_out[i], kv_out[i], kv_out[i]});
        end

        do_txn("mixed", {kv_in[0], kv_in[1], kv_in[2], kv_in[3]}, 1'b0);
        check_eq("mixed_const", w_out_state[1], {kv_out[0], kv_out[1], kv_out[2], kv_out[3]});

        do_txn("bypass", {kv_in[3], kv_in[2], kv_in[1], kv_in[0]}, 1'b1);

        for (int i = 0; i < 24; i++)
            do_txn("rand", {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0));

        // Backpressure: result must hold and new input must be refused.
        s = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_state  = s;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_state = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8 && !w_out_valid[0]; i++) @(negedge clk);
        check_eq("bp_reach", 128'(w_out_valid[0]), 128'(1));
        held = ref_inv_mix(s);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid",    128'(w_out_valid[0]), 128'(1));
            check_eq("bp_state",    w_out_state[0],       held);
            check_eq("bp_in_ready", 128'(w_in_ready[0]),  128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check_eq("bp_rel_ready", 128'(w_in_ready[0]),  128'(1));
        check_eq("bp_rel_valid", 128'(w_out_valid[0]), 128'(0));

        // Asynchronous reset on the second RUN cycle.
        @(negedge clk);
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("mr_busy_pre", 128'(w_busy[0]), 128'(1));
        rst = 1'b1;
        #1;
        check_eq("mr_out_valid", 128'(w_out_valid[0]), 128'(0));
        check_eq("mr_in_ready",  128'(w_in_ready[0]),  128'(1));
        check_eq("mr_busy",      128'(w_busy[0]),      128'(0));
        check_eq("mr_nb_valid",  128'(w_out_valid[2]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        do_txn("post_rst", {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
